// File: rtl/act_skew_feeder.sv
// Diagonal skew feeder for the systolic array: lane i is delayed i cycles, tile flushed with zeros.
// Latency: lane i appears i+1 advances after its vector is accepted; stall freezes all skew state.
// Optional ACT_RELU_EN clamps negative input lanes to zero before they enter the skew registers.
module act_skew_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_SIZE = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [CNT_WIDTH-1:0]             tile_len,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_data,
    input  logic                             stall,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] act_out,
    output logic                             act_valid,
    output logic                             busy,
    output logic                             tile_done
);
    localparam int DW = (ARRAY_SIZE > 2) ? $clog2(ARRAY_SIZE) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] len_q, vec_cnt;
    logic [DW-1:0]        drain_cnt;
    logic                 accept, advance, clear_skew, done_nxt;
    logic                 last_vec, last_drain;

    assign last_vec   = (vec_cnt == len_q - CNT_WIDTH'(1));
    assign last_drain = (drain_cnt == DW'(ARRAY_SIZE - 2));
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        advance    = 1'b0;
        clear_skew = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (tile_len != '0) begin
                        clear_skew = 1'b1;
                        state_nxt  = STREAM;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            STREAM: begin
                in_ready = !stall;
                accept   = in_valid && !stall;
                advance  = accept;
                if (accept && last_vec) state_nxt = DRAIN;
            end
            DRAIN: begin
                advance = !stall;
                if (!stall && last_drain) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q     <= '0;
            vec_cnt   <= '0;
            drain_cnt <= '0;
            act_valid <= 1'b0;
            tile_done <= 1'b0;
        end else begin
            act_valid <= advance;
            tile_done <= done_nxt;
            if (clear_skew) begin
                len_q   <= tile_len;
                vec_cnt <= '0;
            end else if (accept) begin
                vec_cnt <= vec_cnt + CNT_WIDTH'(1);
            end
            if (accept && last_vec)
                drain_cnt <= '0;
            else if (state == DRAIN && advance)
                drain_cnt <= drain_cnt + DW'(1);
        end
    end

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] raw, feed;
        assign raw = in_data[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef ACT_RELU_EN
        assign feed = (state == DRAIN || raw[DATA_WIDTH-1]) ? '0 : raw;
`else
        assign feed = (state == DRAIN) ? '0 : raw;
`endif
        // Lane i is i+1 stages deep; stage 0 takes the new vector
        for (genvar j = 0; j <= i; j++) begin : g_stage
            logic [DATA_WIDTH-1:0] d, q;
            if (j == 0) begin : g_head
                assign d = feed;
            end else begin : g_tail
                assign d = g_stage[j-1].q;
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst)             q <= '0;
                else if (clear_skew) q <= '0;
                else if (advance)    q <= d;
            end
        end
        assign act_out[i*DATA_WIDTH +: DATA_WIDTH] = g_stage[i].q;
    end
endmodule

// File: doc/act_skew_feeder.md
# act_skew_feeder

Upstream stage of the systolic array. It accepts one activation vector per valid/ready handshake and re-times the vector diagonally, delaying lane i by i cycles, so each array row receives its operand on the correct wavefront. It drives the array's per-row activation inputs and enable. After the last vector of a tile it flushes the skew pipeline with zeros and pulses a tile-done flag.

## Interface
Parameters:
- DATA_WIDTH, 8, signed activation width per lane
- ARRAY_SIZE, 32, number of lanes (array rows); must be ≥2
- CNT_WIDTH, 16, width of tile length and vector counters

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a tile; sampled in IDLE only
- tile_len  in  CNT_WIDTH  vectors in tile, unsigned; captured on start
- in_valid  in  1  in_data holds a vector
- in_ready  out  1  block accepts the vector this cycle
- in_data  in  ARRAY_SIZE*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH], signed
- stall  in  1  downstream hold; freezes all skew state
- act_out  out  ARRAY_SIZE*DATA_WIDTH  skewed activations, same lane packing
- act_valid  out  1  act_out advanced this cycle (array enable)
- busy  out  1  state ≠ IDLE
- tile_done  out  1  one-cycle pulse at end of drain

## Operation
- States: IDLE, STREAM, DRAIN.
- IDLE:
  - start=1, tile_len>0: capture tile_len, clear vec_cnt, clear all skew registers, go to STREAM.
  - start=1, tile_len=0: stay IDLE and assert tile_done on the next cycle.
- STREAM:
  - in_ready = !stall.
  - accept = in_valid & in_ready. Each accept is an advance carrying in_data; vec_cnt increments.
  - The accept with vec_cnt = tile_len−1 moves to DRAIN with drain_cnt cleared.
- DRAIN:
  - in_ready=0. Each cycle with !stall is an advance carrying an all-zero vector.
  - After ARRAY_SIZE−1 advances, go to IDLE; tile_done pulses the same cycle.
- Skew: lane i is an (i+1)-deep shift register. act_out lane i is its last stage.
  - Registers shift only on an advance. No advance means every register holds, so lane alignment is preserved across bubbles and stalls.
  - After the k-th advance of a tile, act_out lane i = lane i of the vector carried by advance k−i. It is 0 if k−i<1.
- Arithmetic: pure data movement; values pass through bit-exact except under the configuration option below.
- start while busy: ignored. tile_len changes after capture: ignored.

## Timing
- Reset (async assert, sync release): state=IDLE, all skew registers 0.
  - Outputs: act_out=0, act_valid=0, in_ready=0, busy=0, tile_done=0.
- Reset mid-tile aborts immediately. No tile_done is produced.
- in_ready is combinational from state and stall. in_valid may stay high without being accepted; data must be held by the source.
- act_valid is registered: it is 1 in the cycle after each advance, otherwise 0.
- Latency: lane i of the vector accepted at edge t appears on act_out after edge t+1+i, assuming no stalls.
- Each stall cycle adds one cycle to every pending lane.
- Tile length in cycles, with no stalls or bubbles: 1 (start) + tile_len + ARRAY_SIZE−1.
- tile_done is a registered one-cycle pulse. busy drops in the same cycle.
- A start asserted in the cycle tile_done is high is accepted; IDLE is visible for one cycle.
- stall=1 during the final drain advance delays tile_done until that advance completes.

## Configuration
- ACT_RELU_EN defined: each lane is clamped at the input, so negative in_data values become 0 before entering the skew registers. Drain zeros are unaffected.
- ACT_RELU_EN undefined: values pass unmodified, sign preserved.

## Test plan
All cases use ARRAY_SIZE=4, DATA_WIDTH=8.
- Reset then idle -> act_out=0, act_valid=0, in_ready=0, busy=0.
- start, tile_len=2; vectors {1,2,3,4}, {5,6,7,8} back-to-back -> act_out lane values per cycle:
  - lane 0: 1,5,0,0,0
  - lane 1: 0,2,6,0,0
  - lane 2: 0,0,3,7,0
  - lane 3: 0,0,0,4,8
  - act_valid high for 5 cycles; tile_done one cycle after the last advance.
- Same tile with in_valid low for 2 cycles between the vectors and stall=1 for 1 cycle in DRAIN -> identical act_out sequence on act_valid cycles; act_out holds on the gap cycles; tile_done 3 cycles later.
- start, tile_len=0 -> tile_done pulse next cycle, busy stays 0, act_valid never 1.
- rst asserted after the first accept of tile_len=3 -> all outputs 0 asynchronously; a new start, tile_len=1, vector {9,9,9,9} -> lane i shows 9 at cycle i+1, clean done.
- Vector {−3,5,−128,127}:
  - with ACT_RELU_EN -> lanes emit 0,5,0,127.
  - without -> lanes emit −3,5,−128,127.
